// File: rtl/roi_frame_capture.sv
// ROI crop / optional Bayer 2:1 decimation capture stage between sensor registers and RAW2RGB.
// Optional line-length checking is enabled with `define LINE_CHECK_EN.
module roi_frame_capture #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned XW      = 16,
  parameter int unsigned YW      = 16,
  parameter int unsigned FRAME_W = 32
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic               iSTART,
  input  logic               iEND,
  input  logic [XW-1:0]      iX_START,
  input  logic [XW-1:0]      iX_SIZE,
  input  logic [YW-1:0]      iY_START,
  input  logic [YW-1:0]      iY_SIZE,
  input  logic               iDEC,
  output logic [DATA_W-1:0]  oDATA,
  output logic               oDVAL,
  output logic [XW-1:0]      oX_Cont,
  output logic [YW-1:0]      oY_Cont,
  output logic [FRAME_W-1:0] oFrame_Cont,
  output logic               oBUSY,
  output logic               oLINE_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_LAST} state_t;

  state_t              r_state, w_state_nxt;
  logic                w_frame_inc;
  logic                r_prev_fval, r_prev_lval;
  logic [XW-1:0]       r_rx;
  logic [YW-1:0]       r_ry;
  logic [XW-1:0]       r_x_start, r_x_size;
  logic [YW-1:0]       r_y_start, r_y_size;
  logic                r_dec;
  logic [DATA_W-1:0]   r_data;
  logic                r_dval;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [FRAME_W-1:0]  r_frame;
  logic                r_busy;

  logic                w_fs, w_le, w_pix, w_active, w_dval;
  logic [XW-1:0]       w_x_start, w_x_size, w_ox, w_cx;
  logic [YW-1:0]       w_y_start, w_y_size, w_ry, w_oy, w_cy;
  logic                w_dec, w_in_win, w_keep;

  assign w_fs  = iFVAL & ~r_prev_fval;
  assign w_le  = ~iLVAL & r_prev_lval;
  assign w_pix = iFVAL & iLVAL;

  // On the frame-start cycle the window registers are still loading, so use the inputs directly.
  assign w_x_start = w_fs ? iX_START : r_x_start;
  assign w_x_size  = w_fs ? iX_SIZE  : r_x_size;
  assign w_y_start = w_fs ? iY_START : r_y_start;
  assign w_y_size  = w_fs ? iY_SIZE  : r_y_size;
  assign w_dec     = w_fs ? iDEC     : r_dec;
  assign w_ry      = w_fs ? '0       : r_ry;

  assign w_ox     = r_rx - w_x_start;
  assign w_oy     = w_ry - w_y_start;
  assign w_in_win = (w_ox < w_x_size) && (w_oy < w_y_size);
  assign w_keep   = ~w_dec | (~w_ox[1] & ~w_oy[1]);
  assign w_cx     = w_dec ? XW'({w_ox[XW-1:2], w_ox[0]}) : w_ox;
  assign w_cy     = w_dec ? YW'({w_oy[YW-1:2], w_oy[0]}) : w_oy;
  assign w_active = (r_state == S_RUN) || (r_state == S_LAST);
  assign w_dval   = w_active & w_pix & w_in_win & w_keep;

  // Capture FSM: start/stop only take effect on frame boundaries.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_inc = 1'b0;
    case (r_state)
      S_IDLE:  if (iSTART && !iEND) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (iEND) begin
          w_state_nxt = S_IDLE;
        end else if (w_fs) begin
          w_state_nxt = S_RUN;
          w_frame_inc = 1'b1;
        end
      end
      S_RUN: begin
        if (w_fs) w_frame_inc = 1'b1;
        if (iEND) w_state_nxt = S_LAST;
      end
      S_LAST:  if (!iFVAL || w_fs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Raw position counters and per-frame window latch.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_prev_fval <= 1'b0;
      r_prev_lval <= 1'b0;
      r_rx        <= '0;
      r_ry        <= '0;
      r_x_start   <= '0;
      r_x_size    <= '0;
      r_y_start   <= '0;
      r_y_size    <= '0;
      r_dec       <= 1'b0;
    end else begin
      r_prev_fval <= iFVAL;
      r_prev_lval <= iLVAL;
      if (w_le)                         r_rx <= '0;
      else if (w_pix && (r_rx != '1))   r_rx <= r_rx + XW'(1);
      if (w_fs)                                 r_ry <= '0;
      else if (w_le && iFVAL && (r_ry != '1))   r_ry <= r_ry + YW'(1);
      if (w_fs) begin
        r_x_start <= iX_START;
        r_x_size  <= iX_SIZE;
        r_y_start <= iY_START;
        r_y_size  <= iY_SIZE;
        r_dec     <= iDEC;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_dval  <= 1'b0;
      r_data  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_dval <= w_dval;
      r_data <= w_dval ? iDATA : '0;
      if (w_dval) begin
        r_x <= w_cx;
        r_y <= w_cy;
      end
      if (w_frame_inc) r_frame <= r_frame + FRAME_W'(1);
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign oDATA       = r_data;
  assign oDVAL       = r_dval;
  assign oX_Cont     = r_x;
  assign oY_Cont     = r_y;
  assign oFrame_Cont = r_frame;
  assign oBUSY       = r_busy;

`ifdef LINE_CHECK_EN
  logic [XW-1:0] r_ref_len;
  logic          r_ref_vld;
  logic          r_line_err;

  // First line of each frame sets the reference; later mismatches latch the error.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_ref_len  <= '0;
      r_ref_vld  <= 1'b0;
      r_line_err <= 1'b0;
    end else if (w_fs) begin
      r_ref_vld <= 1'b0;
    end else if (w_le && iFVAL) begin
      if (!r_ref_vld) begin
        r_ref_len <= r_rx;
        r_ref_vld <= 1'b1;
      end else if ((r_rx != r_ref_len) && w_active) begin
        r_line_err <= 1'b1;
      end
    end
  end

  assign oLINE_ERR = r_line_err;
`else
  assign oLINE_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_roi_frame_capture.sv
// Scoreboard bench for roi_frame_capture: a frame-level model predicts every captured pixel.
module tb_roi_frame_capture;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned XW      = 16;
  localparam int unsigned YW      = 16;
  localparam int unsigned FRAME_W = 32;

  logic               iCLK = 1'b0;
  logic               iRST = 1'b1;
  logic [DATA_W-1:0]  iDATA = '0;
  logic               iFVAL = 1'b0;
  logic               iLVAL = 1'b0;
  logic               iSTART = 1'b0;
  logic               iEND = 1'b0;
  logic [XW-1:0]      iX_START = '0;
  logic [XW-1:0]      iX_SIZE = '0;
  logic [YW-1:0]      iY_START = '0;
  logic [YW-1:0]      iY_SIZE = '0;
  logic               iDEC = 1'b0;
  logic [DATA_W-1:0]  oDATA;
  logic               oDVAL;
  logic [XW-1:0]      oX_Cont;
  logic [YW-1:0]      oY_Cont;
  logic [FRAME_W-1:0] oFrame_Cont;
  logic               oBUSY;
  logic               oLINE_ERR;

  roi_frame_capture #(.DATA_W(DATA_W), .XW(XW), .YW(YW), .FRAME_W(FRAME_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .iX_START(iX_START), .iX_SIZE(iX_SIZE),
    .iY_START(iY_START), .iY_SIZE(iY_SIZE), .iDEC(iDEC), .oDATA(oDATA),
    .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
    .oBUSY(oBUSY), .oLINE_ERR(oLINE_ERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [FRAME_W-1:0] f;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Frame-level capture model: enabled, armed, capturing this frame, stop requested.
  bit m_run = 0, m_armed = 0, m_cap = 0, m_stop = 0;
  int m_frames = 0;
  int l_xs, l_xsz, l_ys, l_ysz;
  bit l_dec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic fv, input logic lv, input logic [DATA_W-1:0] d,
                      input logic st, input logic en);
    iFVAL = fv; iLVAL = lv; iDATA = d; iSTART = st; iEND = en;
    @(posedge iCLK);
    #1;
  endtask

  // Expected output for raw pixel (x,y) of the current frame, if any.
  task automatic model_pixel(input int x, input int y, input logic [DATA_W-1:0] d);
    int ox, oy;
    exp_t e;
    if (!m_cap) return;
    ox = (x - l_xs) & 32'hFFFF;
    oy = (y - l_ys) & 32'hFFFF;
    if (ox >= l_xsz || oy >= l_ysz) return;
    if (l_dec) begin
      if (((ox / 2) % 2) != 0 || ((oy / 2) % 2) != 0) return;
      ox = (ox / 4) * 2 + ox % 2;
      oy = (oy / 4) * 2 + oy % 2;
    end
    e.data = d; e.x = XW'(ox); e.y = YW'(oy); e.f = FRAME_W'(m_frames);
    q.push_back(e);
  endtask

  task automatic frame_start_model(input int xs, input int xsz, input int ys, input int ysz,
                                   input bit dec);
    if (m_armed || m_run) begin
      m_armed = 0; m_run = 1; m_cap = 1; m_frames++;
    end else begin
      m_cap = 0;
    end
    l_xs = xs; l_xsz = xsz; l_ys = ys; l_ysz = ysz; l_dec = dec;
  endtask

  task automatic send_frame(input int w, input int h, input int last_w,
                            input int xs, input int xsz, input int ys, input int ysz,
                            input bit dec, input int start_line, input int end_line);
    logic [DATA_W-1:0] d;
    iX_START = XW'(xs); iX_SIZE = XW'(xsz); iY_START = YW'(ys); iY_SIZE = YW'(ysz); iDEC = dec;
    frame_start_model(xs, xsz, ys, ysz, dec);
    tick(1, 0, '0, 0, 0);
    // Window inputs are scrambled mid-frame; only the frame-start values may matter.
    iX_START = XW'($urandom); iX_SIZE = XW'($urandom); iY_START = YW'($urandom);
    iY_SIZE = YW'($urandom); iDEC = 1'($urandom);
    tick(1, 0, '0, 0, 0);
    for (int y = 0; y < h; y++) begin
      int lw;
      lw = (y == h - 1) ? last_w : w;
      for (int x = 0; x < lw; x++) begin
        d = DATA_W'($urandom);
        model_pixel(x, y, d);
        tick(1, 1, d, 0, 0);
      end
      if (y == start_line && !m_run && !m_armed) m_armed = 1;
      if (y == end_line) begin
        m_armed = 0;
        if (m_run) m_stop = 1;
      end
      tick(1, 0, '0, 1'(y == start_line), 1'(y == end_line));
      tick(1, 0, '0, 0, 0);
      tick(1, 0, '0, 0, 0);
    end
    if (m_stop) m_run = 0;
    m_stop = 0;
    m_cap = 0;
    for (int i = 0; i < 4; i++) tick(0, 0, '0, 0, 0);
  endtask

  task automatic pulse(input bit st, input bit en);
    if (en) begin
      m_armed = 0; m_run = 0;
    end else if (st && !m_run && !m_armed) begin
      m_armed = 1;
    end
    tick(0, 0, '0, st, en);
    tick(0, 0, '0, 0, 0);
    tick(0, 0, '0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dval"},  64'(oDVAL), 64'd0);
    check({tag, "_data"},  64'(oDATA), 64'd0);
    check({tag, "_x"},     64'(oX_Cont), 64'd0);
    check({tag, "_y"},     64'(oY_Cont), 64'd0);
    check({tag, "_frame"}, 64'(oFrame_Cont), 64'd0);
    check({tag, "_busy"},  64'(oBUSY), 64'd0);
    check({tag, "_lerr"},  64'(oLINE_ERR), 64'd0);
  endtask

  // Monitor: every presented pixel is matched against the scoreboard head.
  always @(negedge iCLK) begin
    n_vec++;
    if (oDVAL === 1'b1) begin
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pixel: got data %0h x %0d y %0d frame %0d, expected no output",
                 oDATA, oX_Cont, oY_Cont, oFrame_Cont);
      end else begin
        mon_e = q.pop_front();
        if (oDATA !== mon_e.data || oX_Cont !== mon_e.x || oY_Cont !== mon_e.y ||
            oFrame_Cont !== mon_e.f) begin
          n_err++;
          $display("FAIL pixel: got data %0h x %0d y %0d frame %0d, expected data %0h x %0d y %0d frame %0d",
                   oDATA, oX_Cont, oY_Cont, oFrame_Cont, mon_e.data, mon_e.x, mon_e.y, mon_e.f);
        end
      end
    end else if (oDATA !== '0) begin
      n_err++;
      $display("FAIL idle_data: got %0h expected 0 (dval %b)", oDATA, oDVAL);
    end
  end

  initial begin
    int w, h, xs, xsz, ys, ysz;
    bit dec;
    logic [DATA_W-1:0] d;

    iRST = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 0, '0, 0, 0);
    iRST = 1'b0;
    tick(0, 0, '0, 0, 0);
    check_reset_outputs("reset");

    // Full-frame window, three frames.
    pulse(1, 0);
    check("busy_armed", 64'(oBUSY), 64'd1);
    for (int i = 0; i < 3; i++) send_frame(8, 4, 8, 0, 8, 0, 4, 0, -1, -1);
    check("frame_cnt3", 64'(oFrame_Cont), 64'd3);

    // Cropped and decimated windows.
    send_frame(8, 4, 8, 2, 4, 1, 2, 0, -1, -1);
    send_frame(8, 8, 8, 0, 8, 0, 8, 1, -1, -1);

    // Random windows, sizes and decimation, including zero sizes.
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(4, 12); h = $urandom_range(2, 8);
      xs = $urandom_range(0, w); xsz = $urandom_range(0, w);
      ys = $urandom_range(0, h); ysz = $urandom_range(0, h);
      dec = 1'($urandom);
      send_frame(w, h, w, xs, xsz, ys, ysz, dec, -1, -1);
    end
    check("lerr_uniform", 64'(oLINE_ERR), 64'd0);

    // Stop in blanking, then a frame that must not be captured.
    pulse(0, 1);
    check("busy_stopped", 64'(oBUSY), 64'd0);
    send_frame(6, 3, 6, 0, 6, 0, 3, 0, -1, -1);

    // Simultaneous start and stop: stop wins.
    pulse(1, 1);
    check("busy_conflict", 64'(oBUSY), 64'd0);
    send_frame(6, 3, 6, 0, 6, 0, 3, 0, -1, -1);
    check("frame_cnt_hold", 64'(oFrame_Cont), 64'(m_frames));

    // Start mid-frame: nothing from this frame, next frame captured.
    send_frame(8, 4, 8, 0, 8, 0, 4, 0, 1, -1);
    check("busy_midstart", 64'(oBUSY), 64'd1);
    send_frame(8, 4, 8, 1, 5, 0, 3, 0, -1, -1);

    // Stop mid-frame: the frame completes, then idle.
    send_frame(8, 4, 8, 0, 8, 0, 4, 0, -1, 1);
    check("busy_after_end", 64'(oBUSY), 64'd0);
    send_frame(8, 4, 8, 0, 8, 0, 4, 0, -1, -1);

    // Line lengths 8, 8, 7 while running.
    pulse(1, 0);
    send_frame(8, 3, 7, 0, 8, 0, 3, 0, -1, -1);
`ifdef LINE_CHECK_EN
    check("lerr_short_line", 64'(oLINE_ERR), 64'd1);
    send_frame(8, 3, 8, 0, 8, 0, 3, 0, -1, -1);
    check("lerr_sticky", 64'(oLINE_ERR), 64'd1);
`else
    check("lerr_short_line", 64'(oLINE_ERR), 64'd0);
`endif
    check("frame_cnt_end", 64'(oFrame_Cont), 64'(m_frames));

    // Reset in the middle of a line while capturing.
    iX_START = '0; iX_SIZE = XW'(8); iY_START = '0; iY_SIZE = YW'(4); iDEC = 1'b0;
    frame_start_model(0, 8, 0, 4, 0);
    tick(1, 0, '0, 0, 0);
    tick(1, 0, '0, 0, 0);
    for (int x = 0; x < 3; x++) begin
      d = DATA_W'($urandom);
      model_pixel(x, 0, d);
      tick(1, 1, d, 0, 0);
    end
    iRST = 1'b1;
    tick(1, 1, DATA_W'($urandom), 0, 0);
    check_reset_outputs("midline_reset");
    iRST = 1'b0;
    m_run = 0; m_armed = 0; m_cap = 0; m_frames = 0;
    for (int x = 0; x < 5; x++) tick(1, 1, DATA_W'($urandom), 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, '0, 0, 0);
    check("busy_post_reset", 64'(oBUSY), 64'd0);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
